// File: rtl/pw_pkg.sv
// Shared definitions for the password-lock front end: state encoding and
// character width.
package pw_pkg;

  localparam int PW_W = 7;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_RESULT = 2'd1,
    LOCKOUT     = 2'd2
  } pw_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for a data bus plus a synchronized strobe with a
// rising-edge detector.
module sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] data,
  input  logic         strobe,
  output logic [W-1:0] data_sync,
  output logic         strobe_rise
);

  logic [W-1:0] data_meta;
  logic         strobe_meta;
  logic         strobe_sync;
  logic         strobe_prev;

  // Strobe chain resets high so a strobe held through reset never looks
  // like a fresh rising edge once reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_meta   <= '0;
      data_sync   <= '0;
      strobe_meta <= 1'b1;
      strobe_sync <= 1'b1;
      strobe_prev <= 1'b1;
    end else begin
      data_meta   <= data;
      data_sync   <= data_meta;
      strobe_meta <= strobe;
      strobe_sync <= strobe_meta;
      strobe_prev <= strobe_sync;
    end
  end

  assign strobe_rise = strobe_sync & ~strobe_prev;

endmodule

// File: rtl/pw_attempt_ctrl.sv
// Attempt limiter between the PMOD inputs and pw_fsm: turns enter presses
// into submit pulses, judges attempts on open_in, locks out after repeated fails.
module pw_attempt_ctrl
  import pw_pkg::*;
#(
  parameter int PW_LEN      = 4,
  parameter int MAX_FAILS   = 3,
  parameter int RESULT_WAIT = 8,
  parameter int LOCK_CYCLES = 1000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PW_W-1:0]                pw_in,
  input  logic                           enter_in,
  input  logic                           open_in,
  output logic [PW_W-1:0]                char_out,
  output logic                           enter_out,
  output logic                           fsm_hold,
  output logic                           locked,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int SW = $clog2(PW_LEN + 1);
  localparam int WW = $clog2(RESULT_WAIT + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  localparam logic [SW-1:0] SUB_LAST  = SW'(PW_LEN - 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
  localparam logic [WW-1:0] WAIT_INIT = WW'(RESULT_WAIT);
  localparam logic [LW-1:0] LOCK_INIT = LW'(LOCK_CYCLES);

  pw_state_t       state, state_n;
  logic [SW-1:0]   sub_cnt, sub_n;
  logic [WW-1:0]   wait_cnt, wait_n;
  logic [LW-1:0]   lock_cnt, lock_n;
  logic [FW-1:0]   fail_n;
  logic [PW_W-1:0] char_n;
  logic            enter_n;
  logic [PW_W-1:0] pw_sync;
  logic            enter_evt;

  sync_edge #(
    .W (PW_W)
  ) u_sync (
    .clk         (clk),
    .rst         (reset),
    .data        (pw_in),
    .strobe      (enter_in),
    .data_sync   (pw_sync),
    .strobe_rise (enter_evt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sub_cnt    <= '0;
      wait_cnt   <= '0;
      lock_cnt   <= '0;
      fail_count <= '0;
      char_out   <= '0;
      enter_out  <= 1'b0;
    end else begin
      state      <= state_n;
      sub_cnt    <= sub_n;
      wait_cnt   <= wait_n;
      lock_cnt   <= lock_n;
      fail_count <= fail_n;
      char_out   <= char_n;
      enter_out  <= enter_n;
    end
  end

  always_comb begin
    state_n = state;
    sub_n   = sub_cnt;
    wait_n  = wait_cnt;
    lock_n  = lock_cnt;
    fail_n  = fail_count;
    char_n  = char_out;
    enter_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (enter_evt) begin
          enter_n = 1'b1;
          char_n  = pw_sync;
          if (sub_cnt == SUB_LAST) begin
            sub_n   = '0;
            wait_n  = WAIT_INIT;
            state_n = WAIT_RESULT;
          end else begin
            sub_n = sub_cnt + 1'b1;
          end
        end
      end
      WAIT_RESULT: begin
        // Success is checked first so it wins over a same-cycle timeout.
        if (open_in) begin
          fail_n  = '0;
          state_n = IDLE;
        end else if (wait_cnt == WW'(1)) begin
          wait_n = '0;
          if (fail_count >= FAIL_LAST) begin
            fail_n  = FAIL_MAX;
            lock_n  = LOCK_INIT;
            state_n = LOCKOUT;
          end else begin
            fail_n  = fail_count + 1'b1;
            state_n = IDLE;
          end
        end else begin
          wait_n = wait_cnt - 1'b1;
        end
      end
      LOCKOUT: begin
        if (lock_cnt == LW'(1)) begin
          lock_n  = '0;
          fail_n  = '0;
          sub_n   = '0;
          state_n = IDLE;
        end else begin
          lock_n = lock_cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign locked   = (state == LOCKOUT);
  assign fsm_hold = locked;

endmodule

// File: tb/tb_pw_attempt_ctrl.sv
// Scoreboard bench for pw_attempt_ctrl: expected submit characters queued at
// stimulus time and matched against each enter_out pulse.
module tb_pw_attempt_ctrl;

  localparam int PW_LEN      = 2;
  localparam int MAX_FAILS   = 3;
  localparam int RESULT_WAIT = 4;
  localparam int LOCK_CYCLES = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] pw_in = '0;
  logic       enter_in = 1'b0;
  logic       open_in = 1'b0;
  logic [6:0] char_out;
  logic       enter_out;
  logic       fsm_hold;
  logic       locked;
  logic [1:0] fail_count;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];
  logic [6:0] mon_exp;
  int pulse_cnt = 0;
  int lock_run = 0;
  int last_lock_len = 0;
  int exp_fail = 0;
  int base;

  always #5 clk = ~clk;

  pw_attempt_ctrl #(
    .PW_LEN      (PW_LEN),
    .MAX_FAILS   (MAX_FAILS),
    .RESULT_WAIT (RESULT_WAIT),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pw_in      (pw_in),
    .enter_in   (enter_in),
    .open_in    (open_in),
    .char_out   (char_out),
    .enter_out  (enter_out),
    .fsm_hold   (fsm_hold),
    .locked     (locked),
    .fail_count (fail_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (enter_out === 1'b1) begin
      pulse_cnt++;
      if (exp_q.size() == 0) check("unexp_pulse", 1, 0);
      else begin
        mon_exp = exp_q.pop_front();
        check("sb_char", char_out, mon_exp);
      end
    end
    if (locked === 1'b1) lock_run++;
    else if (lock_run != 0) begin
      last_lock_len = lock_run;
      lock_run = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_char"}, char_out, 0);
    check({tag, "_enter"}, enter_out, 0);
    check({tag, "_hold"}, fsm_hold, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_fail"}, fail_count, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("rst");
    tick(2);
    reset = 1'b0;
    exp_fail = 0;
  endtask

  task automatic submit(input logic [6:0] ch, input bit pass);
    @(negedge clk);
    pw_in = ch;
    enter_in = 1'b1;
    if (pass) exp_q.push_back(ch);
    tick(1);
    enter_in = 1'b0;
    tick(2);
  endtask

  // open_at = n raises open_in for the n-th edge after the final pulse.
  task automatic attempt(input logic [6:0] c0, input logic [6:0] c1, input int open_at, input bit poke);
    submit(c0, 1);
    submit(c1, 1);
    if (poke) begin
      submit(7'h11, 0);
      tick(3);
    end else begin
      for (int i = 1; i <= RESULT_WAIT + 2; i++) begin
        open_in = (i == open_at);
        @(negedge clk);
      end
    end
    open_in = 1'b0;
    if (open_at >= 1 && open_at <= RESULT_WAIT) exp_fail = 0;
    else if (exp_fail < MAX_FAILS) exp_fail++;
    check("fail_count", fail_count, exp_fail);
    check("locked", locked, exp_fail == MAX_FAILS);
    check("fsm_hold", fsm_hold, exp_fail == MAX_FAILS);
  endtask

  task automatic wait_unlock();
    for (int n = 0; n < 100 && locked; n++) @(negedge clk);
    check("lock_exit_bound", locked, 0);
  endtask

  initial begin
    // 1: single long submit, latency and one-pulse behaviour
    do_reset();
    @(negedge clk);
    pw_in = 7'h55;
    enter_in = 1'b1;
    exp_q.push_back(7'h55);
    base = pulse_cnt;
    @(negedge clk); check("t1_lat1", enter_out, 0);
    @(negedge clk); check("t1_lat2", enter_out, 0);
    @(negedge clk); check("t1_pulse", enter_out, 1); check("t1_char", char_out, 7'h55);
    @(negedge clk); check("t1_fall", enter_out, 0);
    tick(6);
    enter_in = 1'b0;
    tick(3);
    #1 check("t1_npulse", pulse_cnt - base, 1);
    check("t1_hold_char", char_out, 7'h55);

    // 2: successful attempt, then boundary of the result window
    do_reset();
    submit(7'h21, 1);
    submit(7'h22, 1);
    tick(1);
    open_in = 1'b1;
    tick(1);
    open_in = 1'b0;
    check("t2_fail", fail_count, 0);
    check("t2_locked", locked, 0);
    tick(4);
    submit(7'h23, 1);
    check("t2_fail_after", fail_count, 0);
    do_reset();
    attempt(7'h31, 7'h32, 0, 0);
    attempt(7'h33, 7'h34, RESULT_WAIT, 0);
    attempt(7'h35, 7'h36, RESULT_WAIT + 1, 0);

    // 3: lockout after three fails
    do_reset();
    attempt(7'h01, 7'h02, 0, 0);
    attempt(7'h03, 7'h04, 0, 0);
    attempt(7'h05, 7'h06, 0, 0);
    submit(7'h40, 0);
    submit(7'h41, 0);
    check("t3_still_locked", locked, 1);
    wait_unlock();
    tick(2);
    check("t3_lock_len", last_lock_len, LOCK_CYCLES);
    check("t3_fail_exit", fail_count, 0);
    check("t3_hold_exit", fsm_hold, 0);
    exp_fail = 0;
    submit(7'h42, 1);

    // 4: presses inside the result window are dropped and not counted
    do_reset();
    attempt(7'h51, 7'h52, 0, 1);
    submit(7'h53, 1);
    tick(6);
    check("t4_subcnt", fail_count, 1);
    submit(7'h54, 1);
    tick(6);
    exp_fail = 2;
    check("t4_fail2", fail_count, exp_fail);

    // 5: enter held through reset release and through lockout exit
    @(negedge clk);
    reset = 1'b1;
    enter_in = 1'b1;
    pw_in = 7'h60;
    #1 check_reset_vals("t5_rst");
    tick(3);
    reset = 1'b0;
    exp_fail = 0;
    base = pulse_cnt;
    tick(10);
    #1 check("t5_no_pulse_rst", pulse_cnt - base, 0);
    enter_in = 1'b0;
    tick(3);
    submit(7'h61, 1);
    do_reset();
    attempt(7'h62, 7'h63, 0, 0);
    attempt(7'h64, 7'h65, 0, 0);
    attempt(7'h66, 7'h67, 0, 0);
    @(negedge clk);
    enter_in = 1'b1;
    base = pulse_cnt;
    wait_unlock();
    tick(6);
    #1 check("t5_no_pulse_lock", pulse_cnt - base, 0);
    enter_in = 1'b0;
    exp_fail = 0;
    tick(3);
    submit(7'h6A, 1);

    // 6: reset in the middle of lockout
    do_reset();
    attempt(7'h70, 7'h71, 0, 0);
    attempt(7'h72, 7'h73, 0, 0);
    attempt(7'h74, 7'h75, 0, 0);
    tick(8);
    check("t6_pre_locked", locked, 1);
    @(negedge clk);
    reset = 1'b1;
    #1 check_reset_vals("t6_rst");
    tick(2);
    reset = 1'b0;
    exp_fail = 0;
    submit(7'h76, 1);
    tick(6);
    check("t6_fail_after", fail_count, 0);

    tick(3);
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
